// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and Gray/binary conversion helpers
package fifo_pkg;
    localparam int DEF_ADDR_BITS = 4;
    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Callers zero-extend narrower pointers and truncate the result.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_W; i++) b[i] = ^(g >> i);
        return b;
    endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter of parameterized width
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int W = DEF_ADDR_BITS + 1
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);
    assign o_bin = W'(gray2bin(MAX_W'(i_gray)));
endmodule

// File: rtl/fifo_rd_ptr_empty.sv
// fifo_rd_ptr_empty: read-domain pointer, empty/almost-empty/level and sticky underflow
module fifo_rd_ptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int AE_THRESH = 2
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 r_en,
    input  logic [ADDR_BITS:0]   rq2_w_ptr,
    input  logic                 r_underflow_clr,
    output logic [ADDR_BITS-1:0] r_addr,
    output logic [ADDR_BITS:0]   r_ptr,
    output logic                 r_empty,
    output logic                 r_almost_empty,
    output logic [ADDR_BITS:0]   r_level,
    output logic                 r_underflow
);
    localparam int PW = ADDR_BITS + 1;

    logic [PW-1:0] r_bin;
    logic          w_inc;
    logic [PW-1:0] w_bin_next, w_gray_next, w_wbin, w_level_next;

    gray2bin_conv #(.W(PW)) u_w2b (
        .i_gray (rq2_w_ptr),
        .o_bin  (w_wbin)
    );

    assign w_inc        = r_en & ~r_empty;
    assign w_bin_next   = r_bin + PW'(w_inc);
    assign w_gray_next  = PW'(bin2gray(MAX_W'(w_bin_next)));
    assign w_level_next = w_wbin - w_bin_next;
    assign r_addr       = r_bin[ADDR_BITS-1:0];

    // Flags use next-state pointer so empty asserts on the edge of the last read.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_bin          <= '0;
            r_ptr          <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_bin          <= w_bin_next;
            r_ptr          <= w_gray_next;
            r_empty        <= (w_gray_next == rq2_w_ptr);
            r_almost_empty <= (w_level_next <= PW'(AE_THRESH));
            r_level        <= w_level_next;
            r_underflow    <= (r_en & r_empty) | (r_underflow & ~r_underflow_clr);
        end
    end
endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// tb_fifo_rd_ptr_empty: vector table and scoreboard checks for the read-side controller
module tb_fifo_rd_ptr_empty;
    typedef struct packed {
        logic [3:0] addr;
        logic [4:0] ptr;
        logic       empty;
        logic       ae;
        logic [4:0] level;
        logic       uf;
    } out_t;

    typedef struct packed {
        logic       en;
        logic [4:0] w;
        logic       clr;
        out_t       exp;
    } vec_t;

    logic       r_clk = 1'b0;
    logic       r_rst_n, r_en, r_underflow_clr;
    logic [4:0] rq2_w_ptr;
    logic [3:0] r_addr;
    logic [4:0] r_ptr, r_level;
    logic       r_empty, r_almost_empty, r_underflow;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    out_t sb[$];

    fifo_rd_ptr_empty #(.ADDR_BITS(4), .AE_THRESH(2)) dut (
        .r_clk           (r_clk),
        .r_rst_n         (r_rst_n),
        .r_en            (r_en),
        .rq2_w_ptr       (rq2_w_ptr),
        .r_underflow_clr (r_underflow_clr),
        .r_addr          (r_addr),
        .r_ptr           (r_ptr),
        .r_empty         (r_empty),
        .r_almost_empty  (r_almost_empty),
        .r_level         (r_level),
        .r_underflow     (r_underflow)
    );

    always #5 r_clk = ~r_clk;

    function automatic logic [4:0] g(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    function automatic out_t mk(input int a, input logic [4:0] p, input logic e, input logic ae,
                                input int l, input logic uf);
        out_t o;
        o.addr = a[3:0]; o.ptr = p; o.empty = e; o.ae = ae; o.level = l[4:0]; o.uf = uf;
        return o;
    endfunction

    function automatic vec_t v(input logic en, input logic [4:0] w, input logic clr, input out_t e);
        vec_t t;
        t.en = en; t.w = w; t.clr = clr; t.exp = e;
        return t;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = {r_addr, r_ptr, r_empty, r_almost_empty, r_level, r_underflow};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got addr=%0d ptr=%b empty=%b ae=%b level=%0d uf=%b, expected addr=%0d ptr=%b empty=%b ae=%b level=%0d uf=%b",
                     name, act.addr, act.ptr, act.empty, act.ae, act.level, act.uf,
                     exp.addr, exp.ptr, exp.empty, exp.ae, exp.level, exp.uf);
        end
    endtask

    task automatic run(input string name, input vec_t t);
        r_en = t.en; rq2_w_ptr = t.w; r_underflow_clr = t.clr;
        sb.push_back(t.exp);
        @(posedge r_clk);
        #1;
        check(name, sb.pop_front());
    endtask

    initial begin
        out_t rst_exp;
        rst_exp = mk(0, 5'b00000, 1, 1, 0, 0);
        r_rst_n = 1'b0; r_en = 1'b0; rq2_w_ptr = '0; r_underflow_clr = 1'b0;
        repeat (2) @(posedge r_clk);
        #1 check("reset", rst_exp);
        r_en = 1'b1; rq2_w_ptr = g(3);
        @(posedge r_clk);
        #1 check("reset_en_pulse", rst_exp);
        r_en = 1'b0; rq2_w_ptr = '0;
        @(negedge r_clk) r_rst_n = 1'b1;

        tbl.push_back(v(0, g(3), 0, mk(0, g(0), 0, 0, 3, 0)));
        tbl.push_back(v(1, g(3), 0, mk(1, g(1), 0, 1, 2, 0)));
        tbl.push_back(v(1, g(3), 0, mk(2, g(2), 0, 1, 1, 0)));
        tbl.push_back(v(1, g(3), 0, mk(3, g(3), 1, 1, 0, 0)));
        tbl.push_back(v(1, g(3), 0, mk(3, g(3), 1, 1, 0, 1)));
        tbl.push_back(v(0, g(3), 0, mk(3, g(3), 1, 1, 0, 1)));
        tbl.push_back(v(0, g(3), 1, mk(3, g(3), 1, 1, 0, 0)));
        tbl.push_back(v(1, g(3), 1, mk(3, g(3), 1, 1, 0, 1)));
        tbl.push_back(v(0, g(3), 1, mk(3, g(3), 1, 1, 0, 0)));
        for (int i = 0; i < tbl.size(); i++) run($sformatf("vec%0d", i), tbl[i]);

        run("wrap_fill", v(0, 5'b01000, 0, mk(3, g(3), 0, 0, 12, 0)));
        for (int k = 4; k < 16; k++)
            run($sformatf("drain%0d", k),
                v(1, 5'b01000, 0, mk(k, g(k), k == 15, (15 - k) <= 2, 15 - k, 0)));
        run("wrap_wptr", v(0, 5'b11001, 0, mk(15, 5'b01000, 0, 1, 2, 0)));
        run("wrap_rd1",  v(1, 5'b11001, 0, mk(0, 5'b11000, 0, 1, 1, 0)));
        run("wrap_rd2",  v(1, 5'b11001, 0, mk(1, 5'b11001, 1, 1, 0, 0)));
        run("level5",    v(0, g(22), 0, mk(1, 5'b11001, 0, 0, 5, 0)));

        #3 r_rst_n = 1'b0;
        #1 check("async_reset", rst_exp);
        rq2_w_ptr = '0; r_en = 1'b0;
        @(negedge r_clk) r_rst_n = 1'b1;
        run("post_reset", v(0, 5'b00000, 0, mk(0, 5'b00000, 1, 1, 0, 0)));
        run("full",       v(0, 5'b11000, 0, mk(0, 5'b00000, 0, 0, 16, 0)));
        run("full_rd",    v(1, 5'b11000, 0, mk(1, 5'b00001, 0, 0, 15, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ptr_empty.md
Name: fifo_rd_ptr_empty

Overview:
Read-side pointer and status controller for the dual-clock FIFO. It runs entirely in the read clock domain and consumes the write pointer after it has been synchronized into this domain. It outputs:
- the memory read address,
- the Gray-coded read pointer that is synchronized back into the write domain,
- registered empty, almost-empty and fill-level status,
- a sticky underflow flag.

Parameters:
ADDR_BITS, 4, memory address width; FIFO depth = 2**ADDR_BITS; pointers are ADDR_BITS+1 bits wide.
AE_THRESH, 2, almost-empty asserts when fill level <= AE_THRESH (valid range 0..2**ADDR_BITS-1).

Ports:
r_clk  input  1  read-domain clock; all state updates on its rising edge.
r_rst_n  input  1  asynchronous, active-low reset.
r_en  input  1  read request from the consumer.
rq2_w_ptr  input  ADDR_BITS+1  Gray write pointer, already 2-flop synchronized into r_clk.
r_underflow_clr  input  1  synchronous clear of the sticky underflow flag.
r_addr  output  ADDR_BITS  read address to the dual-port memory.
r_ptr  output  ADDR_BITS+1  registered Gray read pointer, sent to the write-domain synchronizer.
r_empty  output  1  registered empty flag.
r_almost_empty  output  1  registered, level <= AE_THRESH.
r_level  output  ADDR_BITS+1  registered fill-level estimate, 0..2**ADDR_BITS.
r_underflow  output  1  sticky: set on a read attempt while empty.

Behaviour:
- One clock, r_clk. Reset is asynchronous and active-low on r_rst_n. While r_rst_n=0, all outputs are forced immediately, with no clock edge needed:
  - r_addr=0, r_ptr=0, r_level=0
  - r_empty=1, r_almost_empty=1, r_underflow=0
- Internal state is a binary pointer r_bin (ADDR_BITS+1 bits) and a Gray register r_ptr, both updated together.
- r_inc = r_en & ~r_empty. r_bin_next = r_bin + r_inc, which wraps modulo 2**(ADDR_BITS+1).
- r_gray_next = (r_bin_next >> 1) ^ r_bin_next. r_ptr is a plain register; no combinational path from r_en to r_ptr.
- r_addr = r_bin[ADDR_BITS-1:0]. Data for the current head is at r_addr. A read accepted at edge N advances r_addr at edge N.
- Empty: r_empty <= (r_gray_next == rq2_w_ptr).
  - The flag deasserts one r_clk after rq2_w_ptr changes; end-to-end latency from a write is about 3 r_clk plus the write-domain register.
  - It asserts in the same edge as the last read.
- Level: w_bin = gray2bin(rq2_w_ptr); r_level <= (w_bin - r_bin_next) mod 2**(ADDR_BITS+1).
  - Full = 2**ADDR_BITS, i.e. MSBs differ and the lower bits are equal.
  - The value is pessimistic, because the write pointer is delayed by synchronization. It never overstates the true occupancy.
- r_almost_empty <= (level_next <= AE_THRESH), computed from the same next-state level.
- Underflow:
  - r_en=1 while r_empty=1: no pointer change, r_underflow <= 1.
  - r_underflow_clr=1 clears the flag. If clear and a new underflow occur in the same cycle, set wins.
- Wrap: at r_bin=2**ADDR_BITS-1, an accepted read gives r_addr=0 and the pointer MSB toggles. Empty and level comparisons remain correct across the wrap.
- rq2_w_ptr is treated as arbitrary and changes only by Gray single-bit steps. No checks are made on its legality.

Decomposition:
- Shared package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized via width argument or max-width with truncation,
  - the ADDR_BITS default constant.
- One sub-module, gray2bin_conv (combinational, parameterized width), converts rq2_w_ptr. The write-side controller reuses it.

Test Plan:
1. Reset, with ADDR_BITS=4 and AE_THRESH=2:
   - Stimulus: hold r_rst_n=0.
   - Required: r_empty=1, r_almost_empty=1, r_level=0, r_addr=0, r_ptr=5'b00000, r_underflow=0.
   - Pulse r_en: no change.
2. Basic drain:
   - Stimulus: rq2_w_ptr=gray(3)=5'b00010.
   - Required next edge: r_empty=0, r_level=3, r_almost_empty=0.
   - Stimulus: r_en=1 for 3 cycles.
   - Required: r_addr 0,1,2 → 3. After the 3rd edge, r_empty=1, r_level=0, r_ptr=5'b00010. r_almost_empty=1 from the first read (level 2).
3. Underflow:
   - Stimulus: r_en=1 while empty.
   - Required: r_addr/r_ptr unchanged, r_underflow=1 and held.
   - Stimulus: r_underflow_clr=1.
   - Required: cleared.
   - Stimulus: clear and empty-read in the same cycle.
   - Required: r_underflow stays 1.
4. Wrap-around:
   - Stimulus: drain to r_bin=15, then set rq2_w_ptr=gray(17)=5'b11001 and read twice.
   - Required: r_addr 15→0→1, r_ptr 01000→11000→11001, r_empty=1 after the 2nd read.
5. Full level:
   - Stimulus: r_bin=0, rq2_w_ptr=gray(16)=5'b11000.
   - Required: r_level=16, r_empty=0, r_almost_empty=0.
6. Reset mid-operation:
   - Stimulus: assert r_rst_n=0 between clock edges while r_level=5.
   - Required: all outputs reach reset values immediately.
   - Stimulus: release with rq2_w_ptr=0.
   - Required: r_empty stays 1.
